// File: rtl/sts_sync_latch.sv
// Brings multi-field status from the SPI domain into the AXI clock domain.
// Each field is synchronized and debounced, then shown as live, sticky and first-fault views.
module sts_sync_latch #(
    parameter int NUM_FIELDS   = 12,
    parameter int FIELD_W      = 8,
    parameter int SYNC_DEPTH   = 3,
    parameter int STABLE_COUNT = 2,
    localparam int IDX_W       = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [NUM_FIELDS*FIELD_W-1:0] sts_in,
    input  logic [NUM_FIELDS-1:0]         clr,
    input  logic                          clr_first,
    output logic [NUM_FIELDS*FIELD_W-1:0] sts_stable,
    output logic [NUM_FIELDS*FIELD_W-1:0] sts_sticky,
    output logic                          any_sticky,
    output logic                          first_valid,
    output logic [IDX_W-1:0]              first_field,
    output logic [FIELD_W-1:0]            first_data
);

    localparam int CNT_W = (STABLE_COUNT > 0) ? $clog2(STABLE_COUNT + 1) : 1;

    for (genvar f = 0; f < NUM_FIELDS; f++) begin : g_field
        logic [FIELD_W-1:0] r_sync [SYNC_DEPTH];
        logic [FIELD_W-1:0] r_prev;
        logic [CNT_W-1:0]   r_cnt;
        logic               r_acc_en;
        logic [FIELD_W-1:0] r_acc_dat;
        logic [FIELD_W-1:0] r_stable;
        logic [FIELD_W-1:0] r_sticky;
        logic [FIELD_W-1:0] w_dout;
        logic               w_same;
        logic               w_full;

        assign w_dout = r_sync[SYNC_DEPTH-1];
        assign w_same = (w_dout == r_prev);
        assign w_full = (r_cnt == CNT_W'(STABLE_COUNT));

        // Plain multi-bit chain; skewed captures are rejected by the filter below.
        always_ff @(posedge aclk or posedge areset) begin
            if (areset) begin
                for (int k = 0; k < SYNC_DEPTH; k++) begin
                    r_sync[k] <= '0;
                end
            end else begin
                r_sync[0] <= sts_in[f*FIELD_W +: FIELD_W];
                for (int k = 1; k < SYNC_DEPTH; k++) begin
                    r_sync[k] <= r_sync[k-1];
                end
            end
        end

        // Acceptance is registered once before it reaches the live output so the
        // compare/count path and the status register path stay separated.
        always_ff @(posedge aclk or posedge areset) begin
            if (areset) begin
                r_prev    <= '0;
                r_cnt     <= '0;
                r_acc_en  <= 1'b0;
                r_acc_dat <= '0;
                r_stable  <= '0;
            end else begin
                r_prev <= w_dout;
                if (!w_same) begin
                    r_cnt <= '0;
                end else if (!w_full) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                r_acc_en  <= w_full && w_same;
                r_acc_dat <= w_dout;
                if (r_acc_en) begin
                    r_stable <= r_acc_dat;
                end
            end
        end

        // A bit still active in the live view re-sets the sticky bit even while cleared.
        always_ff @(posedge aclk or posedge areset) begin
            if (areset) begin
                r_sticky <= '0;
            end else begin
                r_sticky <= (clr[f] ? '0 : r_sticky) | r_stable;
            end
        end

        assign sts_stable[f*FIELD_W +: FIELD_W] = r_stable;
        assign sts_sticky[f*FIELD_W +: FIELD_W] = r_sticky;
    end

    assign any_sticky = |sts_sticky;

    logic               w_hit;
    logic [IDX_W-1:0]   w_idx;
    logic [FIELD_W-1:0] w_data;

    // Scan from the top down so the lowest-index nonzero field wins.
    always_comb begin
        w_hit  = 1'b0;
        w_idx  = '0;
        w_data = '0;
        for (int f = NUM_FIELDS - 1; f >= 0; f--) begin
            if (|sts_stable[f*FIELD_W +: FIELD_W]) begin
                w_hit  = 1'b1;
                w_idx  = IDX_W'(f);
                w_data = sts_stable[f*FIELD_W +: FIELD_W];
            end
        end
    end

    logic               r_first_valid;
    logic [IDX_W-1:0]   r_first_field;
    logic [FIELD_W-1:0] r_first_data;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_first_valid <= 1'b0;
            r_first_field <= '0;
            r_first_data  <= '0;
        end else if (clr_first) begin
            r_first_valid <= 1'b0;
        end else if (!r_first_valid && w_hit) begin
            r_first_valid <= 1'b1;
            r_first_field <= w_idx;
            r_first_data  <= w_data;
        end
    end

    assign first_valid = r_first_valid;
    assign first_field = r_first_field;
    assign first_data  = r_first_data;

endmodule

// File: tb/tb_sts_sync_latch.sv
// Randomized and directed bench for sts_sync_latch, checked against a
// sample-history model plus two small instances with alternate parameters.
module tb_sts_sync_latch;

  localparam int NF = 12;
  localparam int FW = 8;
  localparam int D  = 3;
  localparam int SC = 2;
  localparam int L  = D + SC + 2;
  localparam int W  = NF * FW;

  logic          aclk = 1'b0;
  logic          areset;
  logic [W-1:0]  sts_in;
  logic [NF-1:0] clr;
  logic          clr_first;
  logic [W-1:0]  sts_stable;
  logic [W-1:0]  sts_sticky;
  logic          any_sticky;
  logic          first_valid;
  logic [3:0]    first_field;
  logic [FW-1:0] first_data;

  logic          sts_in2;
  logic          stable2, sticky2, any2, fv2, ff2, fd2;
  logic [103:0]  sts_in3;
  logic [103:0]  stable3, sticky3;
  logic          any3, fv3;
  logic [3:0]    ff3;
  logic [7:0]    fd3;
  logic          zero1 = 1'b0;
  logic [12:0]   zero13 = '0;

  always #5 aclk = ~aclk;

  sts_sync_latch dut (
    .aclk(aclk), .areset(areset), .sts_in(sts_in), .clr(clr), .clr_first(clr_first),
    .sts_stable(sts_stable), .sts_sticky(sts_sticky), .any_sticky(any_sticky),
    .first_valid(first_valid), .first_field(first_field), .first_data(first_data)
  );

  sts_sync_latch #(.NUM_FIELDS(1), .FIELD_W(1), .SYNC_DEPTH(2), .STABLE_COUNT(1)) dut_small (
    .aclk(aclk), .areset(areset), .sts_in(sts_in2), .clr(zero1), .clr_first(zero1),
    .sts_stable(stable2), .sts_sticky(sticky2), .any_sticky(any2),
    .first_valid(fv2), .first_field(ff2), .first_data(fd2)
  );

  sts_sync_latch #(.NUM_FIELDS(13)) dut_13 (
    .aclk(aclk), .areset(areset), .sts_in(sts_in3), .clr(zero13), .clr_first(zero1),
    .sts_stable(stable3), .sts_sticky(sticky3), .any_sticky(any3),
    .first_valid(fv3), .first_field(ff3), .first_data(fd3)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: a field is accepted once SC+2 consecutive input samples
  // agree, and the agreed value shows up L edges after the first of them.
  logic [W-1:0]  hist[$];
  logic [W-1:0]  m_stable, m_sticky;
  logic          m_fv;
  logic [3:0]    m_ff;
  logic [FW-1:0] m_fd;

  function automatic logic [FW-1:0] fld(input logic [W-1:0] v, input int f);
    return v[f*FW +: FW];
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i <= L; i++) hist.push_back('0);
    m_stable = '0;
    m_sticky = '0;
    m_fv = 1'b0;
    m_ff = '0;
    m_fd = '0;
  endtask

  task automatic model_step();
    logic [W-1:0] nxt, a, b;
    logic ok, found;
    if (areset) begin
      model_reset();
      return;
    end
    hist.push_front(sts_in);
    while (hist.size() > L + 1) void'(hist.pop_back());
    nxt = m_stable;
    b = hist[L];
    for (int f = 0; f < NF; f++) begin
      ok = 1'b1;
      for (int k = D + 1; k < L; k++) begin
        a = hist[k];
        if (fld(a, f) != fld(b, f)) ok = 1'b0;
      end
      if (ok) nxt[f*FW +: FW] = fld(b, f);
    end
    for (int f = 0; f < NF; f++) begin
      m_sticky[f*FW +: FW] = (clr[f] ? 8'h00 : fld(m_sticky, f)) | fld(m_stable, f);
    end
    if (clr_first) begin
      m_fv = 1'b0;
    end else if (!m_fv) begin
      found = 1'b0;
      for (int f = 0; f < NF; f++) begin
        if (!found && fld(m_stable, f) != 0) begin
          found = 1'b1;
          m_fv = 1'b1;
          m_ff = 4'(f);
          m_fd = fld(m_stable, f);
        end
      end
    end
    m_stable = nxt;
  endtask

  task automatic check_all();
    chk("stable", sts_stable, m_stable);
    chk("sticky", sts_sticky, m_sticky);
    chk("any_sticky", any_sticky, |m_sticky);
    chk("first_valid", first_valid, m_fv);
    chk("first_field", first_field, m_ff);
    chk("first_data", first_data, m_fd);
  endtask

  task automatic tick();
    @(posedge aclk);
    model_step();
    @(negedge aclk);
    check_all();
  endtask

  task automatic set_fld(input int f, input logic [FW-1:0] v);
    sts_in[f*FW +: FW] = v;
  endtask

  task automatic quiesce();
    sts_in = '0;
    repeat (10) tick();
    clr = '1;
    clr_first = 1'b1;
    tick();
    clr = '0;
    clr_first = 1'b0;
  endtask

  initial begin
    areset = 1'b1;
    sts_in = '1;
    clr = '0;
    clr_first = 1'b0;
    sts_in2 = 1'b0;
    sts_in3 = '0;
    model_reset();

    // Reset hold with all-ones input, then release with zero input.
    repeat (5) tick();
    areset = 1'b0;
    sts_in = '0;
    repeat (20) tick();
    chk("rst_release_stable", sts_stable, 0);

    // Latency on field 3.
    set_fld(3, 8'hA5);
    tick();
    repeat (6) tick();
    chk("lat_edge6", fld(sts_stable, 3), 8'h00);
    tick();
    chk("lat_edge7", fld(sts_stable, 3), 8'hA5);
    chk("lat_others", sts_stable & ~({{(W-FW){1'b0}}, 8'hFF} << (3*FW)), 0);
    quiesce();

    // Glitch rejection on field 5.
    set_fld(5, 8'h01);
    tick();
    set_fld(5, 8'h00);
    repeat (10) tick();
    chk("glitch_stable", fld(sts_stable, 5), 8'h00);
    chk("glitch_sticky", fld(sts_sticky, 5), 8'h00);
    set_fld(5, 8'h03);
    repeat (10) tick();
    for (int i = 0; i < 16; i++) begin
      set_fld(5, ((i / 2) % 2 == 0) ? 8'h00 : 8'h03);
      tick();
    end
    chk("alt_stable", fld(sts_stable, 5), 8'h03);
    quiesce();

    // Sticky and clear on field 2.
    set_fld(2, 8'h10);
    repeat (10) tick();
    set_fld(2, 8'h00);
    repeat (10) tick();
    chk("stk_stable_back", fld(sts_stable, 2), 8'h00);
    chk("stk_held", fld(sts_sticky, 2), 8'h10);
    chk("stk_any", any_sticky, 1'b1);
    clr[2] = 1'b1;
    tick();
    clr[2] = 1'b0;
    chk("stk_cleared", fld(sts_sticky, 2), 8'h00);
    chk("stk_any_clr", any_sticky, 1'b0);
    set_fld(2, 8'h10);
    repeat (10) tick();
    clr[2] = 1'b1;
    tick();
    clr[2] = 1'b0;
    chk("stk_set_wins", fld(sts_sticky, 2), 8'h10);
    quiesce();

    // First-fault capture and tie-break.
    chk("ff_idle", first_valid, 1'b0);
    set_fld(7, 8'h40);
    set_fld(4, 8'h08);
    repeat (9) tick();
    chk("ff_valid", first_valid, 1'b1);
    chk("ff_field", first_field, 4'd4);
    chk("ff_data", first_data, 8'h08);
    set_fld(1, 8'h02);
    repeat (9) tick();
    chk("ff_frozen", first_field, 4'd4);
    clr_first = 1'b1;
    tick();
    clr_first = 1'b0;
    chk("ff_cleared", first_valid, 1'b0);
    tick();
    chk("ff_recap_field", first_field, 4'd1);
    chk("ff_recap_valid", first_valid, 1'b1);

    // Asynchronous reset mid-run.
    quiesce();
    set_fld(2, 8'h10);
    repeat (10) tick();
    chk("pre_rst_sticky", fld(sts_sticky, 2), 8'h10);
    #2;
    areset = 1'b1;
    model_reset();
    #1;
    check_all();
    chk("async_sticky", sts_sticky, 0);
    chk("async_any", any_sticky, 1'b0);
    @(negedge aclk);
    areset = 1'b0;
    sts_in = '0;
    repeat (5) tick();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      for (int f = 0; f < NF; f++) begin
        if ($urandom_range(0, 7) == 0)
          set_fld(f, ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00);
        clr[f] = ($urandom_range(0, 7) == 0);
      end
      clr_first = ($urandom_range(0, 15) == 0);
      tick();
    end
    clr = '0;
    clr_first = 1'b0;

    // Minimal configuration: latency SYNC_DEPTH+STABLE_COUNT+2 = 5.
    sts_in2 = 1'b1;
    tick();
    repeat (4) tick();
    chk("small_edge4", stable2, 1'b0);
    tick();
    chk("small_edge5", stable2, 1'b1);
    tick();
    chk("small_fv", fv2, 1'b1);
    chk("small_ff", ff2, 1'b0);

    // Thirteen fields: fault on the top field only.
    sts_in3[12*8 +: 8] = 8'h5A;
    repeat (9) tick();
    chk("f13_valid", fv3, 1'b1);
    chk("f13_field", ff3, 4'd12);
    chk("f13_data", fd3, 8'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
